// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC record sequencer.
// ADC_CAPTURE_HDR_EN selects the header beat and the 2-entry output FIFO.
package adc_capture_pkg;

  localparam int DATA_W = 64;
  localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

`ifdef ADC_CAPTURE_HDR_EN
  localparam int OUT_DEPTH = 2;
`else
  localparam int OUT_DEPTH = 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/axis_out_stage.sv
// AXI-Stream output holding stage (1 entry, or 2 with ADC_CAPTURE_HDR_EN).
// Accepts a header and a sample in one cycle; overflowing samples are dropped.
module axis_out_stage
  import adc_capture_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  beat_t             ld_beat,
  input  logic              hdr_push,
  input  beat_t             hdr_beat,
  input  logic              force_last,
  input  logic              tready,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast,
  output logic              held,
  output logic              drop
);

  beat_t      mem [OUT_DEPTH];
  beat_t      nxt [OUT_DEPTH];
  logic [1:0] cnt, n;
  logic       pop;

  assign tvalid = (cnt != 2'd0);
  assign pop    = tvalid && tready;
  assign tdata  = mem[0].data;
  assign tlast  = mem[0].last;
  // A beat that is still here after this edge's handshake.
  assign held   = (cnt - 2'(pop)) != 2'd0;

  always_comb begin
    nxt  = mem;
    n    = cnt;
    drop = 1'b0;
    if (pop) begin
      for (int i = 0; i < OUT_DEPTH - 1; i++) nxt[i] = mem[i+1];
      n = n - 2'd1;
    end
    if (hdr_push && n != 2'(OUT_DEPTH)) begin
      for (int i = 0; i < OUT_DEPTH; i++) if (n == 2'(i)) nxt[i] = hdr_beat;
      n = n + 2'd1;
    end
    if (load) begin
      if (n != 2'(OUT_DEPTH)) begin
        for (int i = 0; i < OUT_DEPTH; i++) if (n == 2'(i)) nxt[i] = ld_beat;
        n = n + 2'd1;
      end else begin
        // Dropped record end still terminates the packet on the newest beat.
        drop = 1'b1;
        if (ld_beat.last)
          for (int i = 0; i < OUT_DEPTH; i++) if (n == 2'(i + 1)) nxt[i].last = 1'b1;
      end
    end
    if (force_last)
      for (int i = 0; i < OUT_DEPTH; i++) if (n == 2'(i + 1)) nxt[i].last = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= 2'd0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= n;
      mem <= nxt;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Record sequencer: level trigger, fixed-length records, holdoff, record limit,
// drop accounting and abort. ADC_CAPTURE_HDR_EN adds a per-record header beat.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 48,
  parameter int CNT_W    = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                s_sample_valid,
  input  logic [SAMPLE_W-1:0] s_sample_data,
  input  logic [63:0]         s_sample_index,
  input  logic [SAMPLE_W-1:0] cfg_level,
  input  logic [CNT_W-1:0]    cfg_post_len,
  input  logic [CNT_W-1:0]    cfg_holdoff,
  input  logic [15:0]         cfg_max_records,
  input  logic                cmd_arm,
  input  logic                cmd_abort,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [63:0]         m_axis_tdata,
  output logic                m_axis_tlast,
  output logic [2:0]          state_o,
  output logic [15:0]         records_done,
  output logic [31:0]         drop_count,
  output logic                busy
);

  state_t                     state, end_st;
  logic signed [SAMPLE_W-1:0] lvl_q;
  logic [CNT_W-1:0]           post_m1_q, hold_q, beat_cnt, hold_cnt;
  logic [15:0]                max_q, rec_inc;
  logic                       flush_wait;
  logic                       trig, arm_ok, is_last, held, drop;
  logic                       ld, ld_last, force_last, hdr_push;
  beat_t                      ld_beat, hdr_beat;
  logic                       unused_idx;

  assign unused_idx = ^s_sample_index[63:INDEX_W];
  assign state_o    = state;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);

  assign trig    = s_sample_valid && ($signed(s_sample_data) > lvl_q);
  assign arm_ok  = cmd_arm && !cmd_abort && (state == ST_IDLE || state == ST_DONE);
  // Comparing against post_len-1 avoids any wrap at post_len = 2^CNT_W-1.
  assign is_last = (beat_cnt == post_m1_q);
  assign rec_inc = records_done + 16'd1;
  assign end_st  = (max_q != 16'd0 && rec_inc == max_q) ? ST_DONE :
                   (hold_q != '0) ? ST_HOLDOFF : ST_ARMED;

  always_comb begin
    ld         = 1'b0;
    ld_last    = is_last;
    force_last = 1'b0;
    case (state)
      ST_ARMED:   ld = trig && !cmd_abort;
      ST_CAPTURE: begin
        ld         = s_sample_valid && !(cmd_abort && held);
        force_last = cmd_abort && held;
        if (cmd_abort) ld_last = 1'b1;
      end
      ST_FLUSH: begin
        ld      = s_sample_valid && flush_wait;
        ld_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign ld_beat.data = {s_sample_index[INDEX_W-1:0], s_sample_data};
  assign ld_beat.last = ld_last;

`ifdef ADC_CAPTURE_HDR_EN
  assign hdr_push      = ld && (state == ST_ARMED);
  assign hdr_beat.data = {HDR_MAGIC, records_done, s_sample_index[31:0]};
  assign hdr_beat.last = 1'b0;
`else
  assign hdr_push = 1'b0;
  assign hdr_beat = '0;
`endif

  axis_out_stage u_out (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load       (ld),
    .ld_beat    (ld_beat),
    .hdr_push   (hdr_push),
    .hdr_beat   (hdr_beat),
    .force_last (force_last),
    .tready     (m_axis_tready),
    .tvalid     (m_axis_tvalid),
    .tdata      (m_axis_tdata),
    .tlast      (m_axis_tlast),
    .held       (held),
    .drop       (drop)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      lvl_q        <= '0;
      post_m1_q    <= '0;
      hold_q       <= '0;
      max_q        <= '0;
      beat_cnt     <= '0;
      hold_cnt     <= '0;
      flush_wait   <= 1'b0;
      records_done <= '0;
      drop_count   <= '0;
    end else begin
      if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
      if (arm_ok) begin
        lvl_q        <= $signed(cfg_level);
        post_m1_q    <= (cfg_post_len == '0) ? '0 : cfg_post_len - 1'b1;
        hold_q       <= cfg_holdoff;
        max_q        <= cfg_max_records;
        beat_cnt     <= '0;
        hold_cnt     <= '0;
        records_done <= '0;
        drop_count   <= '0;
        state        <= ST_ARMED;
      end
      case (state)
        ST_ARMED:
          if (cmd_abort) state <= ST_IDLE;
          else if (trig) begin
            if (is_last) begin
              records_done <= rec_inc;
              hold_cnt     <= '0;
              state        <= end_st;
            end else begin
              beat_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
              state    <= ST_CAPTURE;
            end
          end
        ST_CAPTURE:
          if (cmd_abort) begin
            flush_wait <= !held && !s_sample_valid;
            beat_cnt   <= '0;
            state      <= ST_FLUSH;
          end else if (s_sample_valid) begin
            if (is_last) begin
              records_done <= rec_inc;
              beat_cnt     <= '0;
              hold_cnt     <= '0;
              state        <= end_st;
            end else beat_cnt <= beat_cnt + 1'b1;
          end
        ST_HOLDOFF:
          if (cmd_abort) state <= ST_IDLE;
          else if (s_sample_valid) begin
            if (hold_cnt == hold_q - 1'b1) begin
              hold_cnt <= '0;
              state    <= ST_ARMED;
            end else hold_cnt <= hold_cnt + 1'b1;
          end
        ST_FLUSH: begin
          if (flush_wait && s_sample_valid) flush_wait <= 1'b0;
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state <= ST_IDLE;
        end
        ST_DONE:
          if (cmd_abort) state <= ST_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl (default build, no header beat).
module tb_adc_capture_ctrl;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic        s_sample_valid = 1'b0;
  logic [15:0] s_sample_data = '0;
  logic [63:0] idx = 64'd1000;
  logic [15:0] cfg_level = '0;
  logic [31:0] cfg_post_len = '0, cfg_holdoff = '0;
  logic [15:0] cfg_max_records = '0;
  logic        cmd_arm = 1'b0, cmd_abort = 1'b0, rdy = 1'b1;
  logic        m_axis_tvalid, m_axis_tlast, busy;
  logic [63:0] m_axis_tdata;
  logic [2:0]  state_o;
  logic [15:0] records_done;
  logic [31:0] drop_count;

  typedef struct { logic [63:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   errs = 0, checks = 0;
  logic [63:0] hd;

  always #5 aclk = ~aclk;

  adc_capture_ctrl dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_sample_valid  (s_sample_valid),
    .s_sample_data   (s_sample_data),
    .s_sample_index  (idx),
    .cfg_level       (cfg_level),
    .cfg_post_len    (cfg_post_len),
    .cfg_holdoff     (cfg_holdoff),
    .cfg_max_records (cfg_max_records),
    .cmd_arm         (cmd_arm),
    .cmd_abort       (cmd_abort),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (rdy),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .state_o         (state_o),
    .records_done    (records_done),
    .drop_count      (drop_count),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk); #1;
    idx = idx + 64'd1;
  endtask

  task automatic drive(input logic [15:0] d, input bit expb, input bit expl);
    s_sample_valid = 1'b1;
    s_sample_data  = d;
    if (expb) exp_q.push_back('{{idx[47:0], d}, expl});
    step();
    s_sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_sample_valid = 1'b0;
    repeat (n) step();
  endtask

  // Config is scrambled right after the arm to prove it was latched.
  task automatic arm(input logic [15:0] lvl, input logic [31:0] pl,
                     input logic [31:0] ho, input logic [15:0] mx);
    cfg_level = lvl; cfg_post_len = pl; cfg_holdoff = ho; cfg_max_records = mx;
    cmd_arm = 1'b1;
    step();
    cmd_arm = 1'b0;
    cfg_level = 16'h8000; cfg_post_len = 32'd1; cfg_holdoff = 32'd7; cfg_max_records = 16'd1;
  endtask

  task automatic abort();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
  endtask

  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && rdy) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("tdata", m_axis_tdata, mon_e.d);
        chk("tlast", 64'(m_axis_tlast), 64'(mon_e.l));
      end
    end
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_rec", 64'(records_done), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    aresetn = 1'b1;
    step();

    // Basic record: trigger on 1001, not on 1000.
    arm(16'd1000, 32'd4, 32'd0, 16'd0);
    chk("armed", 64'(state_o), 64'd1);
    chk("armed_busy", 64'(busy), 64'd1);
    drive(16'd900, 0, 0);
    drive(16'd1000, 0, 0);
    drive(16'd1001, 1, 0);
    drive(16'd1002, 1, 0);
    drive(16'd1003, 1, 0);
    drive(16'd1004, 1, 1);
    idle(3);
    chk("t1_rec", 64'(records_done), 64'd1);
    chk("t1_state", 64'(state_o), 64'd1);
    abort();
    chk("t1_abort", 64'(state_o), 64'd0);

    // Holdoff and record limit.
    arm(16'd0, 32'd2, 32'd3, 16'd2);
    drive(16'd100, 1, 0);
    drive(16'd101, 1, 1);
    for (int i = 0; i < 3; i++) drive(16'(102 + i), 0, 0);
    drive(16'd105, 1, 0);
    drive(16'd106, 1, 1);
    for (int i = 0; i < 3; i++) drive(16'(107 + i), 0, 0);
    idle(2);
    chk("t2_state", 64'(state_o), 64'd5);
    chk("t2_rec", 64'(records_done), 64'd2);
    chk("t2_busy", 64'(busy), 64'd0);
    abort();
    chk("t2_abort", 64'(state_o), 64'd0);

    // Backpressure on record cycles 2..4.
    arm(16'd0, 32'd8, 32'd0, 16'd0);
    hd = {idx[47:0], 16'd20};
    drive(16'd20, 1, 0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'(21 + i), 0, 0);
      chk("stall_data", m_axis_tdata, hd);
      chk("stall_vld", 64'(m_axis_tvalid), 64'd1);
    end
    rdy = 1'b1;
    drive(16'd24, 1, 0);
    drive(16'd25, 1, 0);
    drive(16'd26, 1, 0);
    drive(16'd27, 1, 1);
    idle(3);
    chk("t3_drop", 64'(drop_count), 64'd3);
    chk("t3_rec", 64'(records_done), 64'd1);
    abort();

    // Abort on beat 3 while beat 2 is held.
    arm(16'd0, 32'd10, 32'd0, 16'd0);
    drive(16'd10, 1, 0);
    drive(16'd11, 1, 1);
    rdy = 1'b0;
    cmd_abort = 1'b1;
    drive(16'd12, 0, 0);
    cmd_abort = 1'b0;
    drive(16'd13, 0, 0);
    chk("t4_flush", 64'(state_o), 64'd4);
    chk("t4_last", 64'(m_axis_tlast), 64'd1);
    rdy = 1'b1;
    drive(16'd14, 0, 0);
    drive(16'd15, 0, 0);
    chk("t4_idle", 64'(state_o), 64'd0);
    drive(16'd16, 0, 0);

    // Arm+abort together, then signed trigger compare.
    cmd_arm = 1'b1;
    cmd_abort = 1'b1;
    step();
    cmd_arm = 1'b0;
    cmd_abort = 1'b0;
    chk("t5_both", 64'(state_o), 64'd0);
    arm(16'hFFFB, 32'd1, 32'd0, 16'd0);
    drive(16'hFFFB, 0, 0);
    drive(16'hFFFC, 1, 1);
    idle(2);
    chk("t5_rec", 64'(records_done), 64'd1);
    chk("t5_state", 64'(state_o), 64'd1);
    abort();

    // Asynchronous reset mid-record, then post_len=0.
    arm(16'd0, 32'd3, 32'd0, 16'd0);
    rdy = 1'b0;
    drive(16'd5, 0, 0);
    drive(16'd6, 0, 0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("ar_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("ar_tdata", m_axis_tdata, 64'd0);
    chk("ar_tlast", 64'(m_axis_tlast), 64'd0);
    chk("ar_state", 64'(state_o), 64'd0);
    chk("ar_drop", 64'(drop_count), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    rdy = 1'b1;
    step();
    arm(16'd0, 32'd0, 32'd0, 16'd0);
    drive(16'd50, 1, 1);
    idle(3);
    chk("t6_rec", 64'(records_done), 64'd1);
    chk("t6_state", 64'(state_o), 64'd1);

    idle(5);
    chk("q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Record sequencer placed between the ADC sum/trigger datapath and the AXI-Stream DMA/writer.
- Accepts the per-clock sample stream of signed sum values plus the 64-bit sample index.
- Arms on command and detects the level crossing; each crossing becomes one bounded record of exactly cfg_post_len beats with tlast on the final beat.
- Enforces a holdoff between records, a record-count limit, downstream backpressure with drop accounting, and abort.

Parameters:
- SAMPLE_W, 16, width of signed sample value.
- INDEX_W, 48, sample index bits packed into output beat; SAMPLE_W + INDEX_W = 64.
- CNT_W, 32, width of length, holdoff and drop counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_sample_valid  in  1  sample qualifier
- s_sample_data  in  16  signed sum value
- s_sample_index  in  64  free-running sample counter
- cfg_level  in  16  trigger level, signed
- cfg_post_len  in  32  beats per record; 0 treated as 1
- cfg_holdoff  in  32  valid samples ignored after a record
- cfg_max_records  in  16  records per arm; 0 = unlimited
- cmd_arm  in  1  single-cycle pulse, start sequence
- cmd_abort  in  1  single-cycle pulse, stop sequence
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  64  {s_sample_index[47:0], s_sample_data}
- m_axis_tlast  out  1  last beat of record
- state_o  out  3  current FSM state encoding
- records_done  out  16  records completed since arm
- drop_count  out  32  samples lost to backpressure, saturating
- busy  out  1  state != IDLE and != DONE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal counters 0.
- Config capture: cfg_* latched on the cmd_arm cycle; later cfg changes are ignored until the next arm.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, HOLDOFF=3, FLUSH=4, DONE=5.
- IDLE:
  - cmd_arm -> ARMED.
  - records_done and drop_count clear on arm.
- ARMED:
  - Trigger condition: s_sample_valid and $signed(s_sample_data) > $signed(cfg_level). Equality does not trigger.
  - On trigger -> CAPTURE. The triggering sample is beat 1 of the record.
- CAPTURE:
  - Every valid sample is loaded into the output register.
  - Beat counter increments per loaded beat.
  - The beat with count == post_len has tlast=1. After loading it -> HOLDOFF if holdoff > 0, else ARMED. records_done increments at the same time.
- Record-count limit: if records_done+1 == cfg_max_records (nonzero) when tlast is loaded -> DONE instead of HOLDOFF/ARMED.
- HOLDOFF: counts valid samples; after cfg_holdoff of them -> ARMED. No triggers are taken during HOLDOFF.
- DONE: holds until cmd_arm (-> ARMED, counters cleared) or cmd_abort (-> IDLE).
- Output register (one entry):
  - tvalid rises 1 cycle after the sample cycle.
  - Once tvalid=1, tdata and tlast stay stable until tready.
  - Same-cycle handshake plus new load is allowed, giving full throughput.
- Backpressure drop:
  - Applies when a CAPTURE sample arrives while the register is full and tready=0.
  - The sample is dropped and drop_count increments, saturating at 2^32-1.
  - The beat counter still advances, so record length in time is fixed.
  - If the dropped sample was the tlast sample, the tlast flag is OR-ed onto the held beat.
- Abort:
  - In ARMED, HOLDOFF or DONE -> IDLE immediately.
  - In CAPTURE -> FLUSH. If a beat is held, its tlast is forced to 1. Otherwise the next valid sample is loaded with tlast=1.
  - FLUSH -> IDLE after that tlast beat handshakes.
  - Abort during IDLE is ignored.
- Simultaneous cmd_arm and cmd_abort: abort wins.
- cmd_arm while busy: ignored.
- Reset mid-record: tvalid drops asynchronously; downstream must treat this as a packet loss.
- Counter wrap: beat counter and holdoff counter are CNT_W bits. post_len = 2^32-1 must work with no wrap before compare.

Optional Feature:
- Macro: ADC_CAPTURE_HDR_EN.
- Defined:
  - Each record starts with one header beat before beat 1: tdata = {16'hA5C3, records_done, 32'(triggering index[31:0])}, tlast=0.
  - The triggering sample is then emitted as the second beat.
  - Header beats do not count toward post_len.
  - A 2-entry output FIFO replaces the single register so no sample drops at the header under a continuously ready sink.
- Undefined: no header; single-entry output register as above.

Decomposition:
- Package adc_capture_pkg:
  - state enum with the fixed encodings above;
  - HDR_MAGIC = 16'hA5C3;
  - width localparams.
- Sub-module axis_out_stage:
  - output register/FIFO with load, drop and force_last inputs;
  - handshake logic.
- FSM and counters stay in the top module.

Test Plan:
- Arm, level=1000, post_len=4, holdoff=0, tready=1; samples 900, 1000, 1001, ... -> trigger on 1001; 4 beats with indexes N..N+3; tlast on beat 4; records_done=1; state back to ARMED.
- max_records=2, holdoff=3, stream always above level -> record 1, then 3 ignored samples, then record 2; state DONE; no further beats.
- post_len=8, tready low for cycles 2-4 of the record -> drop_count=3; 5 beats emitted; final beat tlast=1; tdata stable while stalled.
- Abort during beat 3 of post_len=10 with a held beat -> that beat has tlast=1; FLUSH then IDLE; no extra beats.
- cmd_arm and cmd_abort in the same cycle from IDLE -> stays IDLE; level=-5 with sample -4 triggers (signed compare), sample -5 does not.
- aresetn low mid-record -> all outputs 0 the same cycle; after release, arm with post_len=0 -> single-beat record with tlast=1.
